// File: rtl/iwm_pkg.sv
// Shared definitions for the IWM register model: soft-switch indices,
// access-select encoding and status/handshake bit positions.
package iwm_pkg;

    localparam logic [2:0] SW_PH0   = 3'd0;
    localparam logic [2:0] SW_PH1   = 3'd1;
    localparam logic [2:0] SW_PH2   = 3'd2;
    localparam logic [2:0] SW_PH3   = 3'd3;
    localparam logic [2:0] SW_MOTOR = 3'd4;
    localparam logic [2:0] SW_DRIVE = 3'd5;
    localparam logic [2:0] SW_Q6    = 3'd6;
    localparam logic [2:0] SW_Q7    = 3'd7;

    // Register selected by {q7,q6}.
    typedef enum logic [1:0] {
        RD_DATA      = 2'b00,
        RD_STATUS    = 2'b01,
        RD_HANDSHAKE = 2'b10,
        WR_MODE_DATA = 2'b11
    } reg_sel_e;

    localparam int ST_SENSE       = 7;
    localparam int ST_MOTOR       = 5;
    localparam int HS_BUF_EMPTY   = 7;
    localparam int HS_NO_UNDERRUN = 6;

endpackage

// File: rtl/iwm_motor_timer.sv
// Effective drive-motor state: on while the motor switch is set, and for
// MOTOR_DELAY_CEN cen pulses after it clears unless the delay is disabled.
module iwm_motor_timer #(
    parameter int unsigned MOTOR_DELAY_CEN = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic cen,
    input  logic motor_on,
    input  logic motor_off,
    input  logic no_delay,
    input  logic drive_35,
    output logic motor_act
);
    localparam int unsigned TW = $clog2(MOTOR_DELAY_CEN + 1);

    logic [TW-1:0] timer;
    logic          hold_off;

    // Both the mode bit and a selected 3.5" drive cancel the spin-down delay.
    assign hold_off = no_delay | drive_35;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (motor_off && !hold_off) begin
            timer <= TW'(MOTOR_DELAY_CEN);
        end else if (motor_on || hold_off) begin
            timer <= '0;
        end else if (cen && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign motor_act = motor_on | ((timer != '0) & ~hold_off);

endmodule

// File: rtl/iwm_ctrl.sv
// Apple IIgs IWM register model at $C0E0-$C0EF: soft switches, mode register,
// motor-off delay and write-buffer handshake; no drive or media is attached.
module iwm_ctrl
    import iwm_pkg::*;
#(
    parameter int unsigned BITCELL_CEN     = 10,
    parameter int unsigned MOTOR_DELAY_CEN = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rw,
    input  logic       strobe,
    input  logic [7:0] DISK35
);
    localparam int unsigned BYTE_SLOW = 8 * BITCELL_CEN;
    localparam int unsigned BYTE_FAST = 8 * (BITCELL_CEN / 2);
    localparam int unsigned CNT_W     = $clog2(BYTE_SLOW);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(BYTE_SLOW - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(BYTE_FAST - 1);

    logic [7:0]       sw;
    logic [7:0]       sw_eff;
    logic [2:0]       sw_idx;
    logic [4:0]       mode;
    logic             motor_act;
    logic             motor_off;
    logic             buf_empty;
    logic             underrun;
    logic [CNT_W-1:0] shift_cnt;
    logic             shift_run;
    logic             byte_end;
    logic             wr_sel;
    logic             mode_wr;
    logic             data_wr;
    reg_sel_e         acc_sel;
    logic             unused_inputs;

    assign sw_idx = addr[3:1];

    // Only the buffer's fill state is observable without a drive, so the
    // write data beyond the mode bits is never stored.
    assign unused_inputs = ^{addr[7:4], din[7:5], DISK35[7], DISK35[5:0]};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        sw_eff         = sw;
        sw_eff[sw_idx] = addr[0];
    end

    assign acc_sel   = reg_sel_e'({sw_eff[SW_Q7], sw_eff[SW_Q6]});
    assign motor_off = strobe & (sw_idx == SW_MOTOR) & ~addr[0] & sw[SW_MOTOR];

    iwm_motor_timer #(
        .MOTOR_DELAY_CEN(MOTOR_DELAY_CEN)
    ) u_motor_timer (
        .clk       (clk),
        .reset     (reset),
        .cen       (cen),
        .motor_on  (sw[SW_MOTOR]),
        .motor_off (motor_off),
        .no_delay  (mode[2]),
        .drive_35  (DISK35[6]),
        .motor_act (motor_act)
    );

    assign wr_sel  = strobe & ~rw & (acc_sel == WR_MODE_DATA);
    assign mode_wr = wr_sel & ~motor_act & addr[0];
    assign data_wr = wr_sel & motor_act;

    // Mode cannot change while the motor runs, so the byte length is stable
    // for the whole time the shifter is active.
    assign shift_run = motor_act & sw[SW_Q7];
    assign byte_end  = shift_run & cen & (shift_cnt == (mode[3] ? LAST_FAST : LAST_SLOW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw        <= '0;
            mode      <= '0;
            buf_empty <= 1'b1;
            underrun  <= 1'b0;
            shift_cnt <= '0;
        end else begin
            if (strobe)
                sw <= sw_eff;
            if (mode_wr)
                mode <= din[4:0];

            if (!shift_run)
                shift_cnt <= '0;
            else if (cen)
                shift_cnt <= byte_end ? '0 : shift_cnt + 1'b1;

            // A CPU write in the same cycle as a byte boundary leaves the new byte queued.
            if (data_wr) begin
                buf_empty <= 1'b0;
                underrun  <= 1'b0;
            end else if (byte_end) begin
                if (buf_empty)
                    underrun <= 1'b1;
                else
                    buf_empty <= 1'b1;
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        if (strobe && rw) begin
            case (acc_sel)
                RD_DATA:      dout = motor_act ? 8'h00 : 8'hFF;
                RD_STATUS: begin
                    dout[ST_SENSE] = 1'b1;
                    dout[ST_MOTOR] = motor_act;
                    dout[4:0]      = mode;
                end
                RD_HANDSHAKE: begin
                    dout                 = 8'h3F;
                    dout[HS_BUF_EMPTY]   = buf_empty;
                    dout[HS_NO_UNDERRUN] = ~underrun;
                end
                default:      dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_iwm_ctrl.sv
// Self-checking bench for iwm_ctrl: directed register scenarios plus random
// accesses compared against a cycle-level behavioural model of the IWM.
module tb_iwm_ctrl;

    localparam int BITCELL  = 10;
    localparam int DELAY    = 20;
    localparam int RAND_CYC = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cen = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       rw = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] disk35 = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] last_dout;

    // Model state
    bit [7:0] m_sw;
    bit [4:0] m_mode;
    int       m_delay;
    bit       m_full;
    bit       m_underrun;
    int       m_cells;

    iwm_ctrl #(
        .BITCELL_CEN    (BITCELL),
        .MOTOR_DELAY_CEN(DELAY)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cen    (cen),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .rw     (rw),
        .strobe (strobe),
        .DISK35 (disk35)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_sw = '0; m_mode = '0; m_delay = 0;
        m_full = 0; m_underrun = 0; m_cells = 0;
    endtask

    function automatic bit model_motor();
        return m_sw[4] || (m_delay > 0 && !m_mode[2] && !disk35[6]);
    endfunction

    function automatic logic [7:0] model_dout(input bit s, input bit r, input bit [7:0] a);
        bit [7:0] eff;
        bit       ma;
        eff = m_sw;
        eff[a[3:1]] = a[0];
        ma = model_motor();
        if (!(s && r)) return 8'h00;
        case ({eff[7], eff[6]})
            2'b00:   return ma ? 8'h00 : 8'hFF;
            2'b01:   return {2'b10, ma, m_mode};
            2'b10:   return {!m_full, !m_underrun, 6'h3F};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input bit s, input bit r, input bit [7:0] a,
                              input bit [7:0] d, input bit c);
        bit [7:0] eff;
        bit       ma, reg11, hold;
        int       byte_len;
        eff = m_sw;
        eff[a[3:1]] = a[0];
        ma    = model_motor();
        reg11 = s && !r && eff[7] && eff[6];
        hold  = m_mode[2] || disk35[6];
        byte_len = m_mode[3] ? 8 * (BITCELL / 2) : 8 * BITCELL;

        if (ma && m_sw[7]) begin
            if (c) m_cells++;
            if (m_cells == byte_len) begin
                m_cells = 0;
                if (m_full) m_full = 0;
                else        m_underrun = 1;
            end
        end else begin
            m_cells = 0;
        end
        if (reg11 && ma) begin
            m_full = 1;
            m_underrun = 0;
        end

        if (s && a[3:1] == 3'd4 && m_sw[4] && !a[0])
            m_delay = hold ? 0 : DELAY;
        else if (s && a[3:1] == 3'd4 && a[0])
            m_delay = 0;
        else if (hold)
            m_delay = 0;
        else if (c && m_delay > 0)
            m_delay--;

        if (reg11 && !ma && a[0]) m_mode = d[4:0];
        if (s) m_sw = eff;
    endtask

    // One clock: drive after the edge, check at the falling edge, advance model.
    task automatic cycle(input bit s, input bit r, input bit [7:0] a,
                         input bit [7:0] d, input bit c);
        strobe = s; rw = r; addr = a; din = d; cen = c;
        @(negedge clk);
        last_dout = dout;
        check("dout", dout, model_dout(s, r, a));
        model_step(s, r, a, d, c);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit [7:0] a);
        cycle(1'b1, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic wr(input bit [7:0] a, input bit [7:0] d);
        cycle(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic idle_cen(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        strobe = 0; cen = 0;
        reset = 1;
        #2;
        check("reset_dout", dout, 8'h00);
        @(negedge clk);
        reset = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mode(input bit [7:0] m);
        rd(8'hED);
        rd(8'hEF);
        wr(8'hEF, m);
        rd(8'hEE);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Reset read sequence
        rd(8'hE0); check("rst_e0", last_dout, 8'hFF);
        rd(8'hEE); check("rst_ee", last_dout, 8'hFF);
        rd(8'hEC); check("rst_ec", last_dout, 8'hFF);
        rd(8'hED);
        rd(8'hEE); check("rst_status", last_dout, 8'h80);

        // Mode register write
        write_mode(8'h1F);
        check("mode_status", last_dout, 8'h9F);

        // Motor-off delay: exactly DELAY cen pulses
        do_reset();
        rd(8'hE9);
        rd(8'hE8);
        for (int k = 0; k < DELAY; k++) begin
            rd(8'hED);
            check("motor_hold", last_dout & 8'h20, 8'h20);
            idle_cen(1);
        end
        rd(8'hED); check("motor_expired", last_dout, 8'h80);

        // mode[2]=1: no delay
        write_mode(8'h04);
        rd(8'hE9);
        rd(8'hE8);
        rd(8'hEE); check("motor_nodelay", last_dout, 8'h84);

        // Write-buffer handshake flow
        do_reset();
        rd(8'hE9);
        rd(8'hED);
        rd(8'hEF);
        wr(8'hED, 8'hD5);
        rd(8'hEC); check("hs_full", last_dout, 8'h7F);
        idle_cen(8 * BITCELL);
        rd(8'hEC); check("hs_sent", last_dout, 8'hFF);
        idle_cen(8 * BITCELL);
        rd(8'hEC); check("hs_underrun", last_dout, 8'hBF);

        // 3.5" drive selected: motor off at once
        do_reset();
        disk35 = 8'h40;
        rd(8'hE9);
        rd(8'hE8);
        rd(8'hED); check("disk35_off", last_dout, 8'h80);
        disk35 = 8'h00;

        // Async reset mid-countdown, no clock edge
        do_reset();
        write_mode(8'h0B);
        rd(8'hE9);
        rd(8'hE8);
        idle_cen(5);
        rd(8'hED); check("countdown", last_dout, 8'hAB);
        rd(8'hEF);
        @(negedge clk);
        #1;
        reset = 1; strobe = 1; rw = 1; addr = 8'hED; cen = 0;
        #1;
        check("async_status", dout, 8'h80);
        addr = 8'hEC;
        #1;
        check("async_data", dout, 8'hFF);
        strobe = 0;
        reset = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Random accesses against the model
        for (int i = 0; i < RAND_CYC; i++) begin
            bit [7:0] a, d;
            bit s, r, c;
            if ($urandom_range(0, 99) == 0) disk35 = 8'($urandom);
            a = 8'hE0 | 8'($urandom_range(0, 15));
            d = 8'($urandom);
            s = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 1) == 1;
            c = $urandom_range(0, 1) == 1;
            cycle(s, r, a, d, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
